// File: rtl/crc8_framer_pkg.sv
// Shared types and constants for the CRC-8 framer.
// Build option: CRC8_FRAMER_SYNC_EN adds a PRE state that emits a sync byte before each frame.
package crc8_framer_pkg;

    localparam logic [7:0] SYNC_BYTE       = 8'hD5;
    localparam logic [7:0] DEFAULT_POLY    = 8'h1D;
    localparam logic [7:0] DEFAULT_INIT    = 8'hFF;
    localparam logic [7:0] DEFAULT_XOR_OUT = 8'h00;

    typedef enum logic [1:0] {
`ifdef CRC8_FRAMER_SYNC_EN
        PRE,
`endif
        DATA,
        CRC
    } state_e;

    // A new frame starts in PRE when sync bytes are enabled, otherwise directly in DATA.
`ifdef CRC8_FRAMER_SYNC_EN
    localparam state_e START_STATE = PRE;
`else
    localparam state_e START_STATE = DATA;
`endif

endpackage

// File: rtl/crc8_framer_if.sv
// Payload-in / framed-out valid-ready streams of the CRC-8 framer.
// The framer itself uses the slave modport; the traffic source/sink uses master.
interface crc8_framer_if;

    logic       s_valid_i;
    logic       s_ready_o;
    logic [7:0] s_data_i;
    logic       s_last_i;

    logic       m_valid_o;
    logic       m_ready_i;
    logic [7:0] m_data_o;
    logic       m_last_o;

    modport slave (
        input  s_valid_i, s_data_i, s_last_i, m_ready_i,
        output s_ready_o, m_valid_o, m_data_o, m_last_o
    );

    modport master (
        output s_valid_i, s_data_i, s_last_i, m_ready_i,
        input  s_ready_o, m_valid_o, m_data_o, m_last_o
    );

endinterface

// File: rtl/crc_calc.sv
// Parameterised bit-serial-unrolled CRC engine; crc_o is the finalised CRC of all bytes since INIT.
// The register is kept in normal (MSB-first) form; reflection is applied at the data input and CRC output.
module crc_calc #(
    parameter int                  DATA_WIDTH = 8,
    parameter int                  CRC_SIZE   = 8,
    parameter logic [CRC_SIZE-1:0] POLY       = 8'h1D,
    parameter logic [CRC_SIZE-1:0] INIT       = 8'hFF,
    parameter bit                  REF_IN     = 1'b1,
    parameter bit                  REF_OUT    = 1'b1,
    parameter logic [CRC_SIZE-1:0] XOR_OUT    = 8'h00
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  soft_reset_i,
    input  logic                  valid_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    output logic [CRC_SIZE-1:0]   crc_o
);

    logic [CRC_SIZE-1:0]   crc_q, crc_d, crc_next, crc_ref;
    logic [DATA_WIDTH-1:0] data_in;

    always_comb begin
        data_in = data_i;
        if (REF_IN) begin
            for (int i = 0; i < DATA_WIDTH; i++) data_in[i] = data_i[DATA_WIDTH-1-i];
        end

        crc_next = crc_q;
        for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
            if (crc_next[CRC_SIZE-1] ^ data_in[i]) crc_next = (crc_next << 1) ^ POLY;
            else                                   crc_next = crc_next << 1;
        end

        // Soft reset wins so a frame boundary always restarts from INIT.
        crc_d = crc_q;
        if (soft_reset_i)  crc_d = INIT;
        else if (valid_i)  crc_d = crc_next;

        crc_ref = crc_q;
        if (REF_OUT) begin
            for (int i = 0; i < CRC_SIZE; i++) crc_ref[i] = crc_q[CRC_SIZE-1-i];
        end
        crc_o = crc_ref ^ XOR_OUT;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) crc_q <= INIT;
        else         crc_q <= crc_d;
    end

endmodule

// File: rtl/crc8_framer.sv
// Appends a CRC-8 byte (m_last_o=1) after each payload frame through a single output register stage.
// Build option: CRC8_FRAMER_SYNC_EN prefixes every frame with SYNC_BYTE (not covered by the CRC).
module crc8_framer
    import crc8_framer_pkg::*;
#(
    parameter logic [7:0] POLY    = DEFAULT_POLY,
    parameter logic [7:0] INIT    = DEFAULT_INIT,
    parameter bit         REF_IN  = 1'b1,
    parameter bit         REF_OUT = 1'b1,
    parameter logic [7:0] XOR_OUT = DEFAULT_XOR_OUT
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    crc8_framer_if.slave  bus,
    output logic [15:0]   frames_o
);

    state_e      state_q, state_d;
    logic        m_valid_q, m_valid_d;
    logic [7:0]  m_data_q, m_data_d;
    logic        m_last_q, m_last_d;
    logic [15:0] frames_q, frames_d;
    logic        out_free, s_ready, crc_soft_reset;
    logic [7:0]  crc_value;

    assign out_free = !m_valid_q || bus.m_ready_i;
    assign s_ready  = rst_ni && (state_q == DATA) && out_free;

    assign bus.s_ready_o = s_ready;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = m_data_q;
    assign bus.m_last_o  = m_last_q;
    assign frames_o      = frames_q;

    crc_calc #(
        .DATA_WIDTH (8),
        .CRC_SIZE   (8),
        .POLY       (POLY),
        .INIT       (INIT),
        .REF_IN     (REF_IN),
        .REF_OUT    (REF_OUT),
        .XOR_OUT    (XOR_OUT)
    ) u_crc (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .soft_reset_i (crc_soft_reset),
        .valid_i      (bus.s_valid_i & s_ready),
        .data_i       (bus.s_data_i),
        .crc_o        (crc_value)
    );

    always_comb begin
        state_d        = state_q;
        m_valid_d      = m_valid_q && !bus.m_ready_i;
        m_data_d       = m_data_q;
        m_last_d       = m_last_q;
        frames_d       = frames_q;
        crc_soft_reset = 1'b0;

        case (state_q)
`ifdef CRC8_FRAMER_SYNC_EN
            PRE: begin
                if (out_free) begin
                    m_valid_d = 1'b1;
                    m_data_d  = SYNC_BYTE;
                    m_last_d  = 1'b0;
                    state_d   = DATA;
                end
            end
`endif
            DATA: begin
                if (bus.s_valid_i && s_ready) begin
                    m_valid_d = 1'b1;
                    m_data_d  = bus.s_data_i;
                    m_last_d  = 1'b0;
                    if (bus.s_last_i) state_d = CRC;
                end
            end
            CRC: begin
                // The engine already holds the last payload byte, so its output is final here.
                if (out_free) begin
                    m_valid_d      = 1'b1;
                    m_data_d       = crc_value;
                    m_last_d       = 1'b1;
                    frames_d       = frames_q + 16'd1;
                    crc_soft_reset = 1'b1;
                    state_d        = START_STATE;
                end
            end
            default: state_d = START_STATE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q   <= START_STATE;
            m_valid_q <= 1'b0;
            m_data_q  <= 8'h00;
            m_last_q  <= 1'b0;
            frames_q  <= 16'h0000;
        end else begin
            state_q   <= state_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_last_q  <= m_last_d;
            frames_q  <= frames_d;
        end
    end

endmodule

// File: tb/tb_crc8_framer.sv
// Directed bench for crc8_framer: known CRC-8 vectors, stalls, back-to-back frames, mid-frame reset.
// Each emitted frame is also run through reference crc_calc instances, which must end with residue 00.
module tb_crc8_framer;

`ifdef CRC8_FRAMER_SYNC_EN
    localparam bit SYNC_EN = 1'b1;
`else
    localparam bit SYNC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] frames;

    crc8_framer_if bus ();

    crc8_framer dut (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .bus      (bus),
        .frames_o (frames)
    );

    always #5 clk = ~clk;

    // Two residue checkers alternate by frame so one can be reset while the other takes the next frame.
    logic [1:0] chk_valid;
    logic [1:0] chk_soft;
    logic [7:0] chk_crc [2];
    logic       parity;
    logic       skip_sync;
    logic       sync_seen;
    logic       residue_pending;

    always_comb begin
        chk_valid = 2'b00;
        if (bus.m_valid_o && bus.m_ready_i && !skip_sync) chk_valid[parity] = 1'b1;
    end

    crc_calc #(.DATA_WIDTH(8), .CRC_SIZE(8), .POLY(8'h1D), .INIT(8'hFF),
               .REF_IN(1'b1), .REF_OUT(1'b1), .XOR_OUT(8'h00)) u_chk0 (
        .clk_i(clk), .rst_ni(rst_n), .soft_reset_i(chk_soft[0]), .valid_i(chk_valid[0]),
        .data_i(bus.m_data_o), .crc_o(chk_crc[0]));

    crc_calc #(.DATA_WIDTH(8), .CRC_SIZE(8), .POLY(8'h1D), .INIT(8'hFF),
               .REF_IN(1'b1), .REF_OUT(1'b1), .XOR_OUT(8'h00)) u_chk1 (
        .clk_i(clk), .rst_ni(rst_n), .soft_reset_i(chk_soft[1]), .valid_i(chk_valid[1]),
        .data_i(bus.m_data_o), .crc_o(chk_crc[1]));

    int pass_count  = 0;
    int check_count = 0;
    int bubbles;

    logic [7:0] tx_data [$];
    logic       tx_last [$];
    logic [7:0] exp_data[$];
    logic       exp_last[$];

    task automatic checkOutput(input string tag, input logic [15:0] got, input logic [15:0] expected);
        check_count++;
        if (got === expected) pass_count++;
        else $display("[TB] FAIL %s: got %h, expected %h", tag, got, expected);
    endtask

    task automatic resetCheckers();
        parity          = 1'b0;
        skip_sync       = SYNC_EN;
        sync_seen       = 1'b0;
        residue_pending = 1'b0;
        chk_soft        = 2'b00;
    endtask

    // Called right after a falling edge, before the next rising edge consumes checker inputs.
    task automatic settleCheckers();
        chk_soft = 2'b00;
        if (sync_seen) begin
            skip_sync = 1'b0;
            sync_seen = 1'b0;
        end
        if (residue_pending) begin
            checkOutput("residue", 16'(chk_crc[parity]), 16'h0000);
            chk_soft[parity] = 1'b1;
            parity           = !parity;
            skip_sync        = SYNC_EN;
            residue_pending  = 1'b0;
        end
    endtask

    // Payload bytes are packed MSB-first in 'bytes'; expected output gets sync, payload and CRC.
    task automatic pushFrame(input logic [71:0] bytes, input int len, input logic [7:0] crc);
        logic [7:0] b;
        if (SYNC_EN) begin
            exp_data.push_back(8'hD5);
            exp_last.push_back(1'b0);
        end
        for (int i = 0; i < len; i++) begin
            b = bytes[8*(len-1-i) +: 8];
            tx_data.push_back(b);
            tx_last.push_back(i == len - 1);
            exp_data.push_back(b);
            exp_last.push_back(1'b0);
        end
        exp_data.push_back(crc);
        exp_last.push_back(1'b1);
    endtask

    task automatic applyStimulus(input bit rand_ready, input int max_cycles);
        int         cyc;
        int         extra;
        bit         started;
        logic       prev_stall;
        logic [7:0] prev_data;
        logic       prev_last;
        cyc        = 0;
        extra      = 0;
        started    = 1'b0;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        prev_last  = 1'b0;
        bubbles    = 0;
        while ((tx_data.size() != 0 || exp_data.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            settleCheckers();
            bus.s_valid_i = (tx_data.size() != 0);
            bus.s_data_i  = (tx_data.size() != 0) ? tx_data[0] : 8'h00;
            bus.s_last_i  = (tx_data.size() != 0) ? tx_last[0] : 1'b0;
            bus.m_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                checkOutput("stall_valid", 16'(bus.m_valid_o), 16'd1);
                checkOutput("stall_data", 16'(bus.m_data_o), 16'(prev_data));
                checkOutput("stall_last", 16'(bus.m_last_o), 16'(prev_last));
            end
            prev_stall = bus.m_valid_o && !bus.m_ready_i;
            prev_data  = bus.m_data_o;
            prev_last  = bus.m_last_o;
            if (bus.s_valid_i && !bus.s_ready_o && started) bubbles++;
            if (bus.s_valid_i && bus.s_ready_o) begin
                void'(tx_data.pop_front());
                void'(tx_last.pop_front());
                started = 1'b1;
            end
            if (bus.m_valid_o && bus.m_ready_i) begin
                if (skip_sync) sync_seen = 1'b1;
                if (bus.m_last_o) residue_pending = 1'b1;
                if (exp_data.size() != 0) begin
                    checkOutput("out_data", 16'(bus.m_data_o), 16'(exp_data[0]));
                    checkOutput("out_last", 16'(bus.m_last_o), 16'(exp_last[0]));
                    void'(exp_data.pop_front());
                    void'(exp_last.pop_front());
                end else begin
                    extra++;
                end
            end
        end
        @(negedge clk);
        settleCheckers();
        bus.s_valid_i = 1'b0;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b0;
        checkOutput("pending_out", 16'(exp_data.size()), 16'd0);
        checkOutput("pending_in", 16'(tx_data.size()), 16'd0);
        checkOutput("extra_bytes", 16'(extra), 16'd0);
        tx_data.delete();
        tx_last.delete();
        exp_data.delete();
        exp_last.delete();
    endtask

    initial begin
        int accepted;
        int budget;

        rst_n         = 1'b0;
        bus.s_valid_i = 1'b1;
        bus.s_data_i  = 8'hA5;
        bus.s_last_i  = 1'b0;
        bus.m_ready_i = 1'b1;
        resetCheckers();

        repeat (3) @(negedge clk);
        #1;
        checkOutput("rst_m_valid", 16'(bus.m_valid_o), 16'd0);
        checkOutput("rst_m_data", 16'(bus.m_data_o), 16'h0000);
        checkOutput("rst_m_last", 16'(bus.m_last_o), 16'd0);
        checkOutput("rst_frames", frames, 16'd0);
        checkOutput("rst_s_ready", 16'(bus.s_ready_o), 16'd0);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        rst_n         = 1'b1;

        $display("[TB] check string 123456789");
        pushFrame("123456789", 9, 8'h97);
        applyStimulus(1'b0, 100);
        checkOutput("frames_1", frames, 16'd1);

        $display("[TB] single byte CD and payload FF FF");
        pushFrame(72'hCD, 1, 8'hF1);
        pushFrame(72'hFFFF, 2, 8'h23);
        applyStimulus(1'b0, 100);
        checkOutput("frames_3", frames, 16'd3);

        $display("[TB] random output backpressure");
        pushFrame("123456789", 9, 8'h97);
        applyStimulus(1'b1, 400);
        checkOutput("frames_4", frames, 16'd4);

        $display("[TB] back-to-back frames");
        pushFrame("123456789", 9, 8'h97);
        pushFrame("123456789", 9, 8'h97);
        applyStimulus(1'b0, 200);
        checkOutput("b2b_bubbles", 16'(bubbles), SYNC_EN ? 16'd2 : 16'd1);
        checkOutput("frames_6", frames, 16'd6);

        $display("[TB] reset in the middle of a frame");
        accepted = 0;
        budget   = 0;
        while (accepted < 4 && budget < 20) begin
            @(negedge clk);
            budget++;
            bus.s_valid_i = 1'b1;
            bus.s_data_i  = 8'h31 + 8'(accepted);
            bus.s_last_i  = 1'b0;
            bus.m_ready_i = 1'b1;
            #1;
            if (bus.s_ready_o) accepted++;
        end
        checkOutput("partial_accepted", 16'(accepted), 16'd4);
        @(negedge clk);
        bus.s_valid_i = 1'b0;
        bus.m_ready_i = 1'b0;
        rst_n         = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("midrst_m_valid", 16'(bus.m_valid_o), 16'd0);
        checkOutput("midrst_m_data", 16'(bus.m_data_o), 16'h0000);
        checkOutput("midrst_frames", frames, 16'd0);
        checkOutput("midrst_s_ready", 16'(bus.s_ready_o), 16'd0);
        rst_n = 1'b1;
        resetCheckers();

        pushFrame("123456789", 9, 8'h97);
        applyStimulus(1'b0, 100);
        checkOutput("frames_after_rst", frames, 16'd1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
